// File: rtl/scpu_mem_sequencer_if.sv
// scpu_mem_sequencer_if: host loader, CPU byte-port and SRAM signals of the sequencer.
// Latency: none, this is wiring only.
// Backpressure: carried by host_req/host_ack and by cpu_enable inside the sequencer.
// Modports: slave = sequencer view, master = host/CPU/SRAM environment view.
interface scpu_mem_sequencer_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  // host loader port
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_go;
  logic          host_stop;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  // CPU instruction / data byte ports
  logic [AW-1:0] cpu_i_addr;
  logic          cpu_d_req;
  logic          cpu_d_we;
  logic [AW-1:0] cpu_d_addr;
  logic [DW-1:0] cpu_d_wdata;
  logic          cpu_halt;
  logic [DW-1:0] cpu_i_rdata;
  logic [DW-1:0] cpu_d_rdata;
  logic          cpu_enable;
  logic          cpu_start;
  // single-port synchronous-read SRAM
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, host_go, host_stop,
    input  cpu_i_addr, cpu_d_req, cpu_d_we, cpu_d_addr, cpu_d_wdata, cpu_halt,
    input  mem_rdata,
    output host_ack, host_rdata, cpu_i_rdata, cpu_d_rdata, cpu_enable, cpu_start,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, host_go, host_stop,
    output cpu_i_addr, cpu_d_req, cpu_d_we, cpu_d_addr, cpu_d_wdata, cpu_halt,
    output mem_rdata,
    input  host_ack, host_rdata, cpu_i_rdata, cpu_d_rdata, cpu_enable, cpu_start,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/scpu_mem_sequencer.sv
// scpu_mem_sequencer: run control for the serial CPU and arbitration of its single-port SRAM.
// Latency: host access acks 2 cycles after grant; CPU read bytes are visible 2 cycles after grant.
// Backpressure: one host access outstanding at a time; a CPU data access stalls fetch via cpu_enable.
// Ports: clk/rst; bus (host loader, CPU byte ports, SRAM side);
//        state (0 IDLE, 1 START, 2 RUN, 3 HALT), timeout (sticky watchdog flag), run_cycles.
module scpu_mem_sequencer #(
  parameter int AW             = 9,
  parameter int DW             = 8,
  parameter int MAX_RUN_CYCLES = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  scpu_mem_sequencer_if.slave bus,
  output logic [1:0]          state,
  output logic                timeout,
  output logic [15:0]         run_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } st_t;

  localparam logic [15:0] WD_LAST = 16'(MAX_RUN_CYCLES - 1);

  st_t           cur_st, nxt_st;
  logic          go_pending, go_pending_nxt;
  logic          host_p1, host_p1_rd, host_ack_r;
  logic          i_p1, d_p1;
  logic          host_own, host_busy, host_grant, go_eff, wd_fire, timeout_set;
  logic          enable_c, start_c;
  logic [AW-1:0] addr_c;
  logic          we_c;
  logic [DW-1:0] wdata_c;
  logic [DW-1:0] host_rdata_r, i_rdata_r, d_rdata_r;

  assign host_own  = (cur_st == ST_IDLE) || (cur_st == ST_HALT);
  // Outstanding from the cycle after grant through the ack cycle; the grant
  // cycle itself is covered by host_grant.
  assign host_busy = host_p1 | host_ack_r;
  // rst gating keeps mem_* at zero while reset is held even if host_req is high.
  assign host_grant = host_own & bus.host_req & ~host_busy & ~rst;
  assign go_eff     = bus.host_go | go_pending;
  assign wd_fire    = (run_cycles == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st     <= ST_IDLE;
      go_pending <= 1'b0;
    end else begin
      cur_st     <= nxt_st;
      go_pending <= go_pending_nxt;
    end
  end

  always_comb begin
    nxt_st         = cur_st;
    go_pending_nxt = go_pending;
    timeout_set    = 1'b0;
    enable_c       = 1'b0;
    start_c        = 1'b0;
    addr_c         = '0;
    we_c           = 1'b0;
    wdata_c        = '0;
    case (cur_st)
      ST_IDLE, ST_HALT: begin
        if (host_grant) begin
          addr_c  = bus.host_addr;
          we_c    = bus.host_we;
          wdata_c = bus.host_wdata;
        end
        // A go that overlaps a host access waits until the ack cycle, so
        // START lands in the cycle after host_ack.
        if (go_eff) begin
          if (host_grant || host_p1) begin
            go_pending_nxt = 1'b1;
          end else begin
            go_pending_nxt = 1'b0;
            nxt_st         = ST_START;
          end
        end
      end
      ST_START: begin
        start_c  = 1'b1;
        enable_c = 1'b1;
        nxt_st   = ST_RUN;
      end
      ST_RUN: begin
        if (bus.cpu_d_req) begin
          addr_c  = bus.cpu_d_addr;
          we_c    = bus.cpu_d_we;
          wdata_c = bus.cpu_d_wdata;
        end else begin
          addr_c   = bus.cpu_i_addr;
          enable_c = 1'b1;
        end
        if (bus.cpu_halt) begin
          nxt_st = ST_HALT;
        end else if (wd_fire) begin
          nxt_st      = ST_HALT;
          timeout_set = 1'b1;
        end else if (bus.host_stop) begin
          nxt_st = ST_IDLE;
        end
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  // Read pipelines, run counter and watchdog flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_p1      <= 1'b0;
      host_p1_rd   <= 1'b0;
      host_ack_r   <= 1'b0;
      i_p1         <= 1'b0;
      d_p1         <= 1'b0;
      host_rdata_r <= '0;
      i_rdata_r    <= '0;
      d_rdata_r    <= '0;
      run_cycles   <= '0;
      timeout      <= 1'b0;
    end else begin
      host_p1    <= host_grant;
      host_p1_rd <= host_grant & ~bus.host_we;
      host_ack_r <= host_p1;
      if (host_p1 && host_p1_rd) host_rdata_r <= bus.mem_rdata;

      i_p1 <= (cur_st == ST_RUN) & ~bus.cpu_d_req;
      d_p1 <= (cur_st == ST_RUN) & bus.cpu_d_req & ~bus.cpu_d_we;
      if (i_p1) i_rdata_r <= bus.mem_rdata;
      if (d_p1) d_rdata_r <= bus.mem_rdata;

      // Clearing on entry makes the START cycle already show the fresh values.
      if (nxt_st == ST_START && cur_st != ST_START) begin
        run_cycles <= '0;
        timeout    <= 1'b0;
      end else if (cur_st == ST_RUN) begin
        if (run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
        if (timeout_set) timeout <= 1'b1;
      end
    end
  end

  assign state           = cur_st;
  assign bus.host_ack    = host_ack_r;
  assign bus.host_rdata  = host_rdata_r;
  assign bus.cpu_i_rdata = i_rdata_r;
  assign bus.cpu_d_rdata = d_rdata_r;
  assign bus.cpu_enable  = enable_c;
  assign bus.cpu_start   = start_c;
  assign bus.mem_addr    = addr_c;
  assign bus.mem_we      = we_c;
  assign bus.mem_wdata   = wdata_c;

endmodule

// File: tb/tb_scpu_mem_sequencer.sv
// tb_scpu_mem_sequencer: directed stimulus for scpu_mem_sequencer with a cycle-keyed scoreboard.
// The stimulus process pushes expected host acks and timed output values; the monitor
// process pops and compares them on the falling edge.
module tb_scpu_mem_sequencer;

  localparam int K_STATE = 0, K_EN = 1, K_START = 2, K_TMO = 3, K_RUNC = 4, K_IRD = 5,
                 K_DRD = 6, K_HRD = 7, K_ACK = 8, K_MADDR = 9, K_MWE = 10;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
    string       name;
  } texp_t;

  typedef struct {
    int         cyc;
    bit         rd;
    logic [7:0] data;
  } hexp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  state;
  logic        timeout;
  logic [15:0] run_cycles;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    wait_expired = 0;
  bit    done = 1'b0;
  bit    finished = 1'b0;
  texp_t tq[$];
  hexp_t host_q[$];
  logic [7:0] sram [512];

  scpu_mem_sequencer_if #(.AW(9), .DW(8)) sif ();

  scpu_mem_sequencer #(.AW(9), .DW(8), .MAX_RUN_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (sif),
    .state      (state),
    .timeout    (timeout),
    .run_cycles (run_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: synchronous read, write in the address cycle.
  always @(posedge clk) begin
    if (sif.mem_we) sram[sif.mem_addr] <= sif.mem_wdata;
    sif.mem_rdata <= sram[sif.mem_addr];
  end

  function automatic logic [15:0] sample(input int k);
    case (k)
      K_STATE: return {14'd0, state};
      K_EN:    return {15'd0, sif.cpu_enable};
      K_START: return {15'd0, sif.cpu_start};
      K_TMO:   return {15'd0, timeout};
      K_RUNC:  return run_cycles;
      K_IRD:   return {8'd0, sif.cpu_i_rdata};
      K_DRD:   return {8'd0, sif.cpu_d_rdata};
      K_HRD:   return {8'd0, sif.host_rdata};
      K_ACK:   return {15'd0, sif.host_ack};
      K_MADDR: return {7'd0, sif.mem_addr};
      K_MWE:   return {15'd0, sif.mem_we};
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: host acks in order, then every timed expectation due this cycle.
  always @(negedge clk) begin
    if (!finished) begin
      if (sif.host_ack === 1'b1) begin
        if (host_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_host_ack: got ack expected none (cycle %0d)", cyc);
        end else begin
          hexp_t h;
          h = host_q.pop_front();
          chk("host_ack_cycle", 16'(cyc), 16'(h.cyc));
          if (h.rd) chk("host_rdata", {8'd0, sif.host_rdata}, {8'd0, h.data});
        end
      end
      for (int i = tq.size() - 1; i >= 0; i--) begin
        if (tq[i].cyc == cyc) begin
          chk(tq[i].name, sample(tq[i].kind), tq[i].val);
          tq.delete(i);
        end
      end
      if (done) begin
        finished = 1'b1;
        chk("host_ack_wait", 16'(wait_expired), 16'd0);
        foreach (tq[i]) begin
          n_checks++;
          $display("FAIL %s: got no sample expected %h at cycle %0d", tq[i].name, tq[i].val, tq[i].cyc);
        end
        foreach (host_q[i]) begin
          n_checks++;
          $display("FAIL host_ack_missing: got none expected ack at cycle %0d", host_q[i].cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int at, input int k, input logic [15:0] v, input string nm);
    texp_t e;
    e.cyc = at; e.kind = k; e.val = v; e.name = nm;
    tq.push_back(e);
  endtask

  // Issues one host access (granted in the current cycle) and holds it until host_ack.
  task automatic host_access(input logic we, input logic [8:0] a, input logic [7:0] wd,
                             input logic [7:0] rd_exp, input logic go);
    hexp_t h;
    bit    seen;
    int    c;
    c = cyc;
    sif.host_req   = 1'b1;
    sif.host_we    = we;
    sif.host_addr  = a;
    sif.host_wdata = wd;
    sif.host_go    = go;
    h.cyc = c + 2; h.rd = !we; h.data = rd_exp;
    host_q.push_back(h);
    exp_at(c, K_MADDR, {7'd0, a}, "mem_addr_host");
    exp_at(c, K_MWE, {15'd0, we}, "mem_we_host");
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sif.host_go = 1'b0;
      if (sif.host_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) wait_expired++;
    tick();
    sif.host_req = 1'b0;
    sif.host_we  = 1'b0;
  endtask

  initial begin
    int g, w, n, c, r;
    rst = 1'b1;
    sif.host_req = 0; sif.host_we = 0; sif.host_addr = '0; sif.host_wdata = '0;
    sif.host_go = 0; sif.host_stop = 0;
    sif.cpu_i_addr = '0; sif.cpu_d_req = 0; sif.cpu_d_we = 0; sif.cpu_d_addr = '0;
    sif.cpu_d_wdata = '0; sif.cpu_halt = 0;
    repeat (3) tick();

    // reset values
    exp_at(cyc, K_STATE, 0, "rst_state");   exp_at(cyc, K_EN, 0, "rst_enable");
    exp_at(cyc, K_START, 0, "rst_start");   exp_at(cyc, K_TMO, 0, "rst_timeout");
    exp_at(cyc, K_RUNC, 0, "rst_run_cycles"); exp_at(cyc, K_IRD, 0, "rst_i_rdata");
    exp_at(cyc, K_DRD, 0, "rst_d_rdata");   exp_at(cyc, K_HRD, 0, "rst_host_rdata");
    exp_at(cyc, K_ACK, 0, "rst_host_ack");  exp_at(cyc, K_MADDR, 0, "rst_mem_addr");
    exp_at(cyc, K_MWE, 0, "rst_mem_we");
    tick();
    rst = 1'b0;
    tick();

    // host loads and read-back
    host_access(1'b1, 9'd0, 8'h00, 8'h00, 1'b0);
    host_access(1'b1, 9'd1, 8'h48, 8'h00, 1'b0);
    host_access(1'b1, 9'd2, 8'hAB, 8'h00, 1'b0);
    host_access(1'b0, 9'd1, 8'h00, 8'h48, 1'b0);

    // start and fetch
    g = cyc;
    sif.host_go = 1'b1;
    sif.cpu_i_addr = 9'd0;
    exp_at(g, K_STATE, 0, "go_state_idle");
    exp_at(g + 1, K_STATE, 1, "go_state_start");
    exp_at(g + 1, K_START, 1, "go_cpu_start");
    exp_at(g + 1, K_EN, 1, "go_enable_start");
    exp_at(g + 2, K_STATE, 2, "go_state_run");
    exp_at(g + 2, K_START, 0, "go_start_pulse_end");
    exp_at(g + 2, K_EN, 1, "go_enable_run");
    exp_at(g + 2, K_MADDR, 0, "first_fetch_addr");
    exp_at(g + 4, K_IRD, 8'h00, "fetch_addr0");
    exp_at(g + 5, K_IRD, 8'h48, "fetch_addr1");
    exp_at(g + 6, K_IRD, 8'h00, "fetch_addr0_again");
    tick(); sif.host_go = 1'b0;            // g+1
    tick();                                // g+2
    tick(); sif.cpu_i_addr = 9'd1;         // g+3
    tick(); sif.cpu_i_addr = 9'd0;         // g+4

    // data read stall
    tick();                                // g+5
    sif.cpu_d_req = 1'b1; sif.cpu_d_we = 1'b0; sif.cpu_d_addr = 9'd2;
    exp_at(g + 5, K_EN, 0, "dread_stall");
    exp_at(g + 5, K_MADDR, 2, "dread_addr");
    exp_at(g + 6, K_EN, 1, "dread_fetch_resume");
    exp_at(g + 7, K_DRD, 8'hAB, "dread_data");
    exp_at(g + 7, K_IRD, 8'h00, "i_rdata_hold");
    tick(); sif.cpu_d_req = 1'b0;          // g+6

    // data write then halt
    tick();                                // g+7
    sif.cpu_d_req = 1'b1; sif.cpu_d_we = 1'b1; sif.cpu_d_addr = 9'd3; sif.cpu_d_wdata = 8'h3C;
    exp_at(g + 7, K_MWE, 1, "dwrite_we");
    exp_at(g + 7, K_MADDR, 3, "dwrite_addr");
    exp_at(g + 7, K_EN, 0, "dwrite_stall");
    tick();                                // g+8
    sif.cpu_d_req = 1'b0; sif.cpu_d_we = 1'b0; sif.cpu_halt = 1'b1;
    tick(); sif.cpu_halt = 1'b0;           // g+9
    exp_at(g + 9, K_STATE, 3, "halt_state");
    exp_at(g + 9, K_RUNC, 7, "halt_run_cycles");
    exp_at(g + 9, K_TMO, 0, "halt_no_timeout");
    exp_at(g + 9, K_DRD, 8'hAB, "dwrite_no_readback");
    exp_at(g + 9, K_EN, 0, "halt_enable");
    exp_at(g + 12, K_RUNC, 7, "halt_run_cycles_frozen");
    host_access(1'b0, 9'd3, 8'h00, 8'h3C, 1'b0);

    // watchdog, with a host request ignored during RUN
    w = cyc;
    sif.host_go = 1'b1;
    exp_at(w + 1, K_STATE, 1, "wd_start");
    exp_at(w + 1, K_RUNC, 0, "wd_run_cycles_cleared");
    exp_at(w + 4, K_MADDR, 0, "run_ignores_host_addr");
    exp_at(w + 4, K_MWE, 0, "run_ignores_host_we");
    exp_at(w + 5, K_ACK, 0, "run_no_host_ack");
    exp_at(w + 17, K_STATE, 2, "wd_last_run_cycle");
    exp_at(w + 17, K_TMO, 0, "wd_timeout_before");
    exp_at(w + 18, K_STATE, 3, "wd_halt");
    exp_at(w + 18, K_TMO, 1, "wd_timeout_set");
    exp_at(w + 18, K_RUNC, 16, "wd_run_cycles");
    tick(); sif.host_go = 1'b0;            // w+1
    tick();                                // w+2
    tick();                                // w+3
    sif.host_req = 1'b1; sif.host_we = 1'b1; sif.host_addr = 9'd5; sif.host_wdata = 8'h77;
    tick(); tick(); tick();                // w+6
    sif.host_req = 1'b0; sif.host_we = 1'b0;
    repeat (13) tick();                    // w+19

    // new go clears timeout, then host_stop aborts to IDLE
    n = cyc;
    sif.host_go = 1'b1;
    exp_at(n + 1, K_TMO, 0, "go_clears_timeout");
    exp_at(n + 1, K_RUNC, 0, "go_clears_run_cycles");
    exp_at(n + 3, K_STATE, 0, "stop_to_idle");
    exp_at(n + 3, K_RUNC, 1, "stop_run_cycles");
    tick(); sif.host_go = 1'b0;            // n+1
    tick(); sif.host_stop = 1'b1;          // n+2
    tick(); sif.host_stop = 1'b0;          // n+3

    // host_go together with a granted host_req
    c = cyc;
    exp_at(c + 2, K_STATE, 0, "pending_go_wait");
    exp_at(c + 2, K_START, 0, "pending_go_no_start");
    exp_at(c + 3, K_STATE, 1, "pending_go_start_state");
    exp_at(c + 3, K_START, 1, "pending_go_cpu_start");
    exp_at(c + 4, K_STATE, 2, "pending_go_run");
    exp_at(c + 5, K_STATE, 3, "halt_beats_stop");
    exp_at(c + 5, K_TMO, 0, "halt_beats_stop_tmo");
    host_access(1'b1, 9'd4, 8'h55, 8'h00, 1'b1);   // returns at c+3
    tick();                                // c+4
    sif.cpu_halt = 1'b1; sif.host_stop = 1'b1;
    tick();                                // c+5
    sif.cpu_halt = 1'b0; sif.host_stop = 1'b0;

    // reset in the middle of RUN
    r = cyc;
    sif.host_go = 1'b1;
    exp_at(r + 2, K_STATE, 2, "pre_rst_run");
    tick(); sif.host_go = 1'b0;            // r+1
    tick();                                // r+2
    tick();                                // r+3
    sif.cpu_d_req = 1'b1; sif.cpu_d_addr = 9'd7;
    #1;
    rst = 1'b1;
    exp_at(r + 3, K_STATE, 0, "mid_rst_state");
    exp_at(r + 3, K_EN, 0, "mid_rst_enable");
    exp_at(r + 3, K_START, 0, "mid_rst_start");
    exp_at(r + 3, K_RUNC, 0, "mid_rst_run_cycles");
    exp_at(r + 3, K_DRD, 0, "mid_rst_d_rdata");
    exp_at(r + 3, K_HRD, 0, "mid_rst_host_rdata");
    exp_at(r + 3, K_MADDR, 0, "mid_rst_mem_addr");
    exp_at(r + 3, K_MWE, 0, "mid_rst_mem_we");
    tick(); sif.cpu_d_req = 1'b0;
    tick(); rst = 1'b0;
    repeat (3) tick();
    done = 1'b1;
  end

endmodule
